// File: rtl/fwrisc_trace_pkg.sv
// Shared types for the execution-trace capture buffer: record tags and the
// packed record layout that is stored in the FIFO and presented to the sink.
package fwrisc_trace_pkg;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_EXEC   = 2'd1,
    EV_RWRITE = 2'd2
  } ev_kind_t;

  typedef struct packed {
    ev_kind_t    kind;
    logic [31:0] a;
    logic [31:0] b;
  } trace_rec_t;

  localparam int unsigned REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/fwrisc_trace_fifo_mem.sv
// Trace record storage: two write ports for dual-event cycles and one
// asynchronous read port so the head record is visible without a bubble.
module fwrisc_trace_fifo_mem
  import fwrisc_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     we0_i,
  input  logic [$clog2(DEPTH)-1:0] waddr0_i,
  input  trace_rec_t               wdata0_i,
  input  logic                     we1_i,
  input  logic [$clog2(DEPTH)-1:0] waddr1_i,
  input  trace_rec_t               wdata1_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output trace_rec_t               rdata_o
);

  trace_rec_t mem_q [DEPTH];

  // The two write addresses are always consecutive, so they never collide.
  always_ff @(posedge clock) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fwrisc_trace_buffer.sv
// Captures instruction-retire and register-write trace events into a lossy FIFO
// and drains them one record per cycle over a valid/ready stream.
module fwrisc_trace_buffer
  import fwrisc_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [31:0]              addr,
  input  logic [31:0]              instr,
  input  logic                     ivalid,
  input  logic [31:0]              raddr,
  input  logic [31:0]              rdata,
  input  logic                     rwrite,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [1:0]               ev_kind,
  output logic [31:0]              ev_a,
  output logic [31:0]              ev_b,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [AW-1:0]     wptr_q, rptr_q, wptr_inc;
  logic [LW-1:0]     level_q, level_d, free, npush_w;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_cnt_q, drop_sat;
  logic [DROP_W:0]   drop_sum;

  logic       ev_i, ev_r, push_ok, drop, pop, we0, we1;
  logic [1:0] npush;
  trace_rec_t rec_exec, rec_rw, wdata0, wdata1, rd_rec;

  // Only the 5-bit register index is carried in the record.
  logic unused_raddr;
  assign unused_raddr = ^raddr[31:5];

  always_comb begin
    ev_i     = enable & ivalid;
    ev_r     = enable & rwrite;
    npush    = {1'b0, ev_i} + {1'b0, ev_r};
    npush_w  = LW'(npush);
    // Free space is taken before this cycle's pop; all-or-nothing push.
    free     = LW'(DEPTH) - level_q;
    push_ok  = npush_w <= free;
    drop     = (npush != 2'd0) && !push_ok;
    pop      = (level_q != '0) && ev_ready;
    we0      = reset && push_ok && (npush != 2'd0);
    we1      = reset && push_ok && (npush == 2'd2);
    wptr_inc = wptr_q + AW'(1);

    rec_exec = '{kind: EV_EXEC, a: addr, b: instr};
    rec_rw   = '{kind: EV_RWRITE, a: {27'd0, raddr[4:0]}, b: rdata};
    wdata0   = ev_i ? rec_exec : rec_rw;
    wdata1   = rec_rw;

    level_d  = level_q + (push_ok ? npush_w : '0) - LW'(pop);
    drop_sum = {1'b0, drop_cnt_q} + (DROP_W + 1)'(npush);
    drop_sat = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (we0) wptr_q <= we1 ? wptr_q + AW'(2) : wptr_inc;
      if (pop) rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      // A drop in the same cycle as a clear restarts the count from this cycle.
      if (drop) begin
        overflow_q <= 1'b1;
        drop_cnt_q <= clr_ovf ? DROP_W'(npush) : drop_sat;
      end else if (clr_ovf) begin
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end
    end
  end

  fwrisc_trace_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clock    (clock),
    .we0_i    (we0),
    .waddr0_i (wptr_q),
    .wdata0_i (wdata0),
    .we1_i    (we1),
    .waddr1_i (wptr_inc),
    .wdata1_i (wdata1),
    .raddr_i  (rptr_q),
    .rdata_o  (rd_rec)
  );

  always_comb begin
    ev_valid = level_q != '0;
    ev_kind  = ev_valid ? rd_rec.kind : EV_NONE;
    ev_a     = ev_valid ? rd_rec.a : 32'd0;
    ev_b     = ev_valid ? rd_rec.b : 32'd0;
    level    = level_q;
    overflow = overflow_q;
    drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_fwrisc_trace_buffer.sv
// Self-checking bench for fwrisc_trace_buffer using a record scoreboard and a
// behavioural occupancy/drop model.
module tb_fwrisc_trace_buffer;
  import fwrisc_trace_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DROP_W = 16;
  localparam int          MAXCNT = 65535;

  logic        clock = 1'b0;
  logic        reset, enable, ivalid, rwrite, ev_ready, clr_ovf;
  logic [31:0] addr, instr, raddr, rdata;
  logic        ev_valid, overflow;
  logic [1:0]  ev_kind;
  logic [31:0] ev_a, ev_b;
  logic [4:0]  level;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  trace_rec_t sb[$];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;

  always #5 clock = ~clock;

  fwrisc_trace_buffer #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .instr    (instr),
    .ivalid   (ivalid),
    .raddr    (raddr),
    .rdata    (rdata),
    .rwrite   (rwrite),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_kind  (ev_kind),
    .ev_a     (ev_a),
    .ev_b     (ev_b),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  // Drives one cycle, updates the model from pre-edge state and reports the
  // record the DUT presented plus the one the scoreboard expected to pop.
  task automatic drive(input logic en, iv, rw, input logic [31:0] a, ins, ra, rd,
                       input logic rdy, clr, output logic popped,
                       output trace_rec_t exp, output trace_rec_t act);
    int npush, free, sum;
    enable = en; ivalid = iv; rwrite = rw; addr = a; instr = ins;
    raddr = ra; rdata = rd; ev_ready = rdy; clr_ovf = clr;
    act    = {ev_kind, ev_a, ev_b};
    free   = DEPTH - sb.size();
    npush  = en ? (int'(iv) + int'(rw)) : 0;
    popped = 1'b0;
    exp    = '0;
    if (sb.size() != 0 && rdy) begin
      popped = 1'b1;
      exp    = sb.pop_front();
    end
    if (clr) begin m_ovf = 1'b0; m_cnt = 0; end
    if (npush > free) begin
      m_ovf = 1'b1;
      sum   = m_cnt + npush;
      m_cnt = (sum > MAXCNT) ? MAXCNT : sum;
    end else begin
      if (en && iv) sb.push_back('{kind: EV_EXEC, a: a, b: ins});
      if (en && rw) sb.push_back('{kind: EV_RWRITE, a: {27'd0, ra[4:0]}, b: rd});
    end
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b1; ivalid = 1'b1; rwrite = 1'b1;
    addr = 32'hdead0000; instr = 32'hbeef; raddr = 32'd3; rdata = 32'd7;
    ev_ready = 1'b0; clr_ovf = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1; ivalid = 1'b0; rwrite = 1'b0;
    sb.delete(); m_cnt = 0; m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({ev_valid, level, overflow, drop_cnt} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b level=%0d ovf=%b cnt=%0d, want all 0",
               ev_valid, level, overflow, drop_cnt);
    end
    n_cmp++;
    if ({ev_kind, ev_a, ev_b} !== 66'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {ev_kind, ev_a, ev_b});
    end
  endtask

  task automatic test_single();
    logic p; trace_rec_t e, a;
    drive(1, 1, 0, 32'h80000000, 32'h00100093, 0, 0, 1, 0, p, e, a);
    n_cmp++;
    if ({ev_valid, ev_kind, ev_a, ev_b} !== {1'b1, EV_EXEC, 32'h80000000, 32'h00100093}) begin
      n_bad++;
      $display("FAIL single_present: got v=%b k=%0d a=%h b=%h want 1/1/80000000/00100093",
               ev_valid, ev_kind, ev_a, ev_b);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, p, e, a);
    n_cmp++;
    if (!p || a !== e) begin
      n_bad++;
      $display("FAIL single_pop: popped=%b got %h want %h", p, a, e);
    end
    n_cmp++;
    if (level !== 5'd0 || ev_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_level: got level=%0d valid=%b want 0/0", level, ev_valid);
    end
  endtask

  task automatic test_dual();
    logic p; trace_rec_t e, a;
    drive(1, 1, 1, 32'h80000004, 32'h00000013, 32'h1, 32'h1, 0, 0, p, e, a);
    n_cmp++;
    if (level !== 5'd2) begin
      n_bad++;
      $display("FAIL dual_level: got %0d want 2", level);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0, p, e, a);
      n_cmp++;
      if (!p || a !== e) begin
        n_bad++;
        $display("FAIL dual_pop%0d: popped=%b got %h want %h", i, p, a, e);
      end
    end
    n_cmp++;
    if (e !== '{kind: EV_RWRITE, a: 32'h1, b: 32'h1}) begin
      n_bad++;
      $display("FAIL dual_order: last popped %h want RWRITE a=1 b=1", e);
    end
  endtask

  task automatic test_fill();
    logic p; trace_rec_t e, a;
    for (int i = 0; i < 15; i++) drive(1, 1, 0, 32'h1000 + i, i, 0, 0, 0, 0, p, e, a);
    n_cmp++;
    if (level !== 5'd15) begin
      n_bad++;
      $display("FAIL fill_level15: got %0d want 15", level);
    end
    drive(1, 1, 1, 32'h2000, 0, 32'd5, 32'h55, 0, 0, p, e, a);
    n_cmp++;
    if (level !== 5'd15 || overflow !== 1'b1 || drop_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL fill_dual_drop: got level=%0d ovf=%b cnt=%0d want 15/1/2",
               level, overflow, drop_cnt);
    end
    drive(1, 1, 0, 32'h3000, 1, 0, 0, 0, 0, p, e, a);
    n_cmp++;
    if (level !== 5'd16 || drop_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL fill_to_full: got level=%0d cnt=%0d want 16/2", level, drop_cnt);
    end
    drive(1, 1, 0, 32'h4000, 2, 0, 0, 0, 0, p, e, a);
    n_cmp++;
    if (level !== 5'd16 || drop_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL full_single_drop: got level=%0d cnt=%0d want 16/3", level, drop_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0, p, e, a);
      n_cmp++;
      if (!p || a !== e) begin
        n_bad++;
        $display("FAIL fill_drain%0d: popped=%b got %h want %h", i, p, a, e);
      end
    end
  endtask

  task automatic test_clr();
    logic p; trace_rec_t e, a;
    for (int i = 0; i < 16; i++) drive(1, 1, 0, 32'h5000 + i, i, 0, 0, 0, 0, p, e, a);
    drive(1, 1, 0, 32'h6000, 0, 0, 0, 0, 1, p, e, a);
    n_cmp++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd1 || drop_cnt !== 16'(m_cnt)) begin
      n_bad++;
      $display("FAIL clr_with_drop: got ovf=%b cnt=%0d want 1/1", overflow, drop_cnt);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, p, e, a);
    n_cmp++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL clr_alone: got ovf=%b cnt=%0d want 0/0", overflow, drop_cnt);
    end
    for (int i = 0; i < 16 && sb.size() != 0; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0, p, e, a);
      n_cmp++;
      if (!p || a !== e) begin
        n_bad++;
        $display("FAIL clr_drain%0d: popped=%b got %h want %h", i, p, a, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic p; trace_rec_t e, a;
    int rx = 0;
    for (int i = 0; i < 80; i++) begin
      drive(1, (i % 2) == 0, 0, 32'((i / 2) * 4), 32'h13, 0, 0, (i % 2) == 0, 0, p, e, a);
      if (p) begin
        n_cmp++;
        if (a !== e || a.a !== 32'(rx * 4)) begin
          n_bad++;
          $display("FAIL wrap_order%0d: got %h want %h addr %h", rx, a, e, rx * 4);
        end
        rx++;
      end
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0, p, e, a);
      n_cmp++;
      if (!p || a !== e || a.a !== 32'(rx * 4)) begin
        n_bad++;
        $display("FAIL wrap_drain%0d: got %h want %h", rx, a, e);
      end
      rx++;
    end
    n_cmp++;
    if (rx != 40 || level !== 5'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_end: got rx=%0d level=%0d cnt=%0d ovf=%b want 40/0/0/0",
               rx, level, drop_cnt, overflow);
    end
  endtask

  task automatic test_reset_mid();
    logic p; trace_rec_t e, a;
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 32'h7000 + i, i, 0, 0, 0, 0, p, e, a);
    drive(1, 0, 1, 0, 0, 32'd9, 32'h99, 0, 0, p, e, a);
    n_cmp++;
    if (level !== 5'd5) begin
      n_bad++;
      $display("FAIL mid_level5: got %0d want 5", level);
    end
    do_reset();
    n_cmp++;
    if (ev_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got valid=%b level=%0d ovf=%b want 0/0/0",
               ev_valid, level, overflow);
    end
    drive(1, 0, 1, 0, 0, 32'hffffffe7, 32'hcafe, 0, 0, p, e, a);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, p, e, a);
    n_cmp++;
    if (!p || a !== e || a !== '{kind: EV_RWRITE, a: 32'h7, b: 32'hcafe}) begin
      n_bad++;
      $display("FAIL mid_recapture: popped=%b got %h want %h", p, a, e);
    end
  endtask

  task automatic test_disable();
    logic p; trace_rec_t e, a;
    for (int i = 0; i < 16; i++) drive(1, 1, 0, 32'h9000 + i, i, 0, 0, 0, 0, p, e, a);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 32'hA000, 1, 2, 3, 0, 0, p, e, a);
    n_cmp++;
    if (level !== 5'd16 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL disable_full: got level=%0d ovf=%b cnt=%0d want 16/0/0",
               level, overflow, drop_cnt);
    end
    for (int i = 0; i < 16; i++) drive(0, 1, 1, 32'hB000, 1, 2, 3, 1, 0, p, e, a);
    n_cmp++;
    if (level !== 5'd0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL disable_drain: got level=%0d want 0", level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_fill();
    test_clr();
    test_wrap();
    test_reset_mid();
    test_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
